// File: rtl/ram_port_arbiter.sv
// Two-port req/ack arbiter in front of a single-port synchronous RAM.
// Port 0 is the CPU load/store path and port 1 is the loader/debug path.
// Each transaction runs IDLE -> GRANT -> RESP and takes three cycles.
// Arbitration is round-robin, or fixed priority with a port 1 starvation guard.
// Ports:
//   clock, reset           rising-edge clock; async active-high reset
//   pN_req/we/addr/wdata   port N request, held high until its ack
//   pN_ack, pN_rdata       one-cycle completion pulse; read data held afterwards
//   ram_addr/wdata/we      registered RAM pins
//   ram_rdata              RAM read data, registered inside the RAM
//   busy, grant_id         transaction in flight; current or last owner
module ram_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 18,
   parameter int RR_MODE  = 1,
   parameter int MAX_WAIT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              grant_id
);

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_we_q, ram_we_d;
   logic              txn_we_q, txn_we_d;
   logic              p0_ack_q, p0_ack_d;
   logic              p1_ack_q, p1_ack_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
   logic              busy_q, busy_d;
   logic              grant_id_q, grant_id_d;
   logic              last_grant_q, last_grant_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              win1;

   always_comb begin
      state_d      = state_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = ram_we_q;
      txn_we_d     = txn_we_q;
      p0_ack_d     = 1'b0;
      p1_ack_d     = 1'b0;
      p0_rdata_d   = p0_rdata_q;
      p1_rdata_d   = p1_rdata_q;
      busy_d       = busy_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      wait_cnt_d   = wait_cnt_q;
      win1         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               if (p0_req && p1_req) begin
                  if (RR_MODE != 0)
                     win1 = ~last_grant_q;
                  else
                     win1 = (wait_cnt_q == WAIT_LIM);
               end else begin
                  win1 = p1_req;
               end

               ram_addr_d   = win1 ? p1_addr : p0_addr;
               ram_wdata_d  = win1 ? p1_wdata : p0_wdata;
               ram_we_d     = win1 ? p1_we : p0_we;
               // ram_we drops after GRANT; remember the direction for RESP
               txn_we_d     = win1 ? p1_we : p0_we;
               grant_id_d   = win1;
               last_grant_d = win1;
               busy_d       = 1'b1;
               state_d      = GRANT;

               // port 1 losses are only tracked in fixed-priority mode
               if (RR_MODE == 0) begin
                  if (win1)
                     wait_cnt_d = 4'd0;
                  else if (p1_req && wait_cnt_q != 4'hF)
                     wait_cnt_d = wait_cnt_q + 4'd1;
               end
            end
         end
         GRANT: begin
            ram_we_d = 1'b0;
            state_d  = RESP;
         end
         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (grant_id_q) begin
               p1_ack_d = 1'b1;
               if (!txn_we_q)
                  p1_rdata_d = ram_rdata;
            end else begin
               p0_ack_d = 1'b1;
               if (!txn_we_q)
                  p0_rdata_d = ram_rdata;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
         txn_we_q     <= 1'b0;
         p0_ack_q     <= 1'b0;
         p1_ack_q     <= 1'b0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
         busy_q       <= 1'b0;
         grant_id_q   <= 1'b0;
         last_grant_q <= 1'b1;
         wait_cnt_q   <= 4'd0;
      end else begin
         state_q      <= state_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
         txn_we_q     <= txn_we_d;
         p0_ack_q     <= p0_ack_d;
         p1_ack_q     <= p1_ack_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
         busy_q       <= busy_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign p0_ack    = p0_ack_q;
   assign p1_ack    = p1_ack_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_we    = ram_we_q;
   assign busy      = busy_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin and a fixed-priority instance,
// each with its own RAM, checked every cycle against a transaction model.
module tb_ram_port_arbiter;

   localparam int MAXW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // index [d][p]: d=0 round-robin, d=1 fixed priority; p = port
   logic        req[2][2];
   logic        we[2][2];
   logic [9:0]  addr[2][2];
   logic [17:0] wd[2][2];
   logic        ack[2][2];
   logic [17:0] rd[2][2];
   logic [9:0]  r_addr[2];
   logic [17:0] r_wd[2];
   logic [17:0] r_rd[2];
   logic        r_we[2];
   logic        busy[2];
   logic        gid[2];

   ram_port_arbiter #(.RR_MODE(1), .MAX_WAIT(MAXW)) u_rr (
      .clock(clk), .reset(rst),
      .p0_req(req[0][0]), .p0_we(we[0][0]),
      .p0_addr(addr[0][0]), .p0_wdata(wd[0][0]),
      .p0_ack(ack[0][0]), .p0_rdata(rd[0][0]),
      .p1_req(req[0][1]), .p1_we(we[0][1]),
      .p1_addr(addr[0][1]), .p1_wdata(wd[0][1]),
      .p1_ack(ack[0][1]), .p1_rdata(rd[0][1]),
      .ram_addr(r_addr[0]), .ram_wdata(r_wd[0]),
      .ram_we(r_we[0]), .ram_rdata(r_rd[0]),
      .busy(busy[0]), .grant_id(gid[0])
   );

   ram_port_arbiter #(.RR_MODE(0), .MAX_WAIT(MAXW)) u_fx (
      .clock(clk), .reset(rst),
      .p0_req(req[1][0]), .p0_we(we[1][0]),
      .p0_addr(addr[1][0]), .p0_wdata(wd[1][0]),
      .p0_ack(ack[1][0]), .p0_rdata(rd[1][0]),
      .p1_req(req[1][1]), .p1_we(we[1][1]),
      .p1_addr(addr[1][1]), .p1_wdata(wd[1][1]),
      .p1_ack(ack[1][1]), .p1_rdata(rd[1][1]),
      .ram_addr(r_addr[1]), .ram_wdata(r_wd[1]),
      .ram_we(r_we[1]), .ram_rdata(r_rd[1]),
      .busy(busy[1]), .grant_id(gid[1])
   );

   // synchronous single-port RAMs, read data registered
   logic [17:0] mem0[1024];
   logic [17:0] mem1[1024];
   always @(posedge clk) begin
      if (r_we[0]) mem0[r_addr[0]] <= r_wd[0];
      r_rd[0] <= mem0[r_addr[0]];
      if (r_we[1]) mem1[r_addr[1]] <= r_wd[1];
      r_rd[1] <= mem1[r_addr[1]];
   end

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model state, per instance
   bit          act[2];
   int          dec[2];
   bit          win[2];
   bit          wwe[2];
   bit          last[2];
   int          wc[2];
   logic [17:0] e_rd[2][2];
   logic [9:0]  e_addr[2];
   logic [17:0] e_wd[2];
   bit          e_gid[2];
   logic [17:0] mm[2][1024];

   int glog_rr[$];
   int glog_fx[$];
   int exp_rr[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   int exp_fx[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(int d);
      act[d]     = 1'b0;
      dec[d]     = -10;
      last[d]    = 1'b1;
      wc[d]      = 0;
      e_rd[d][0] = '0;
      e_rd[d][1] = '0;
      e_addr[d]  = '0;
      e_wd[d]    = '0;
      e_gid[d]   = 1'b0;
   endtask

   // called right after each rising edge with the inputs it sampled
   task automatic model_edge(int d);
      int age;
      bit w;
      if (rst) begin
         model_reset(d);
         return;
      end
      age = cyc - dec[d];
      if (act[d] && age == 2 && !wwe[d])
         e_rd[d][win[d]] = mm[d][e_addr[d]];
      if (act[d] && age >= 3)
         act[d] = 1'b0;
      if (!act[d] && (req[d][0] || req[d][1])) begin
         if (!(req[d][0] && req[d][1]))
            w = req[d][1];
         else if (d == 0)
            w = !last[d];
         else
            w = (wc[d] == MAXW);
         if (d == 1) begin
            if (w)
               wc[d] = 0;
            else if (req[d][1])
               wc[d] = (wc[d] < 15) ? wc[d] + 1 : 15;
         end
         act[d]    = 1'b1;
         dec[d]    = cyc;
         win[d]    = w;
         wwe[d]    = we[d][w];
         last[d]   = w;
         e_gid[d]  = w;
         e_addr[d] = addr[d][w];
         e_wd[d]   = wd[d][w];
         if (wwe[d])
            mm[d][e_addr[d]] = e_wd[d];
      end
   endtask

   task automatic check_all(int d);
      int age;
      bit in_txn;
      age    = cyc - dec[d];
      in_txn = act[d];
      chk($sformatf("d%0d busy", d), busy[d], in_txn && age < 2);
      chk($sformatf("d%0d ram_we", d), r_we[d],
          in_txn && age == 0 && wwe[d]);
      chk($sformatf("d%0d ack0", d), ack[d][0],
          in_txn && age == 2 && win[d] == 1'b0);
      chk($sformatf("d%0d ack1", d), ack[d][1],
          in_txn && age == 2 && win[d] == 1'b1);
      chk($sformatf("d%0d rdata0", d), rd[d][0], e_rd[d][0]);
      chk($sformatf("d%0d rdata1", d), rd[d][1], e_rd[d][1]);
      chk($sformatf("d%0d ram_addr", d), r_addr[d], e_addr[d]);
      chk($sformatf("d%0d ram_wdata", d), r_wd[d], e_wd[d]);
      chk($sformatf("d%0d grant_id", d), gid[d], e_gid[d]);
      if (d == 0) begin
         if (ack[0][0]) glog_rr.push_back(0);
         if (ack[0][1]) glog_rr.push_back(1);
      end else begin
         if (ack[1][0]) glog_fx.push_back(0);
         if (ack[1][1]) glog_fx.push_back(1);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) model_edge(d);
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_all(d);
   endtask

   task automatic drop_all();
      for (int d = 0; d < 2; d++) begin
         req[d][0] = 1'b0;
         req[d][1] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drop_all();
      step();
      step();
      rst = 1'b0;
   endtask

   // one transaction on port p of both instances, req dropped on ack
   task automatic txn(bit p, bit w, logic [9:0] a, logic [17:0] v);
      int n[2];
      bit got[2];
      for (int d = 0; d < 2; d++) begin
         n[d]       = 0;
         got[d]     = 1'b0;
         req[d][p]  = 1'b1;
         we[d][p]   = w;
         addr[d][p] = a;
         wd[d][p]   = v;
      end
      for (int i = 1; i <= 8 && !(got[0] && got[1]); i++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            if (!got[d] && ack[d][p]) begin
               got[d]    = 1'b1;
               n[d]      = i;
               req[d][p] = 1'b0;
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d latency", d), n[d], 3);
         req[d][p] = 1'b0;
      end
   endtask

   task automatic rand_fields(int d, int p);
      we[d][p]   = 1'($urandom_range(0, 1));
      addr[d][p] = 10'($urandom_range(0, 15));
      wd[d][p]   = 18'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ack;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            req[d][p]  = 1'b0;
            we[d][p]   = 1'b0;
            addr[d][p] = '0;
            wd[d][p]   = '0;
         end
         model_reset(d);
      end

      // reset, then idle
      step();
      step();
      rst = 1'b0;
      repeat (10) step();

      // port 0 write then read back
      txn(1'b0, 1'b1, 10'h005, 18'h2ABCD);
      txn(1'b0, 1'b0, 10'h005, 18'h0);
      for (int d = 0; d < 2; d++)
         chk($sformatf("d%0d rd 005", d), rd[d][0], 18'h2ABCD);

      txn(1'b1, 1'b1, 10'h010, 18'h11111);
      txn(1'b0, 1'b1, 10'h020, 18'h22222);
      txn(1'b1, 1'b1, 10'h3FF, 18'h15A5A);
      for (int i = 0; i < 16; i++)
         txn(1'(i % 2), 1'b1, 10'(i), 18'($urandom));

      // both ports reading continuously
      do_reset();
      glog_rr.delete();
      glog_fx.delete();
      for (int d = 0; d < 2; d++) begin
         req[d][0]  = 1'b1;
         we[d][0]   = 1'b0;
         addr[d][0] = 10'h010;
         req[d][1]  = 1'b1;
         we[d][1]   = 1'b0;
         addr[d][1] = 10'h020;
      end
      repeat (24) step();
      drop_all();
      repeat (3) step();
      chk("rr grants", glog_rr.size(), 8);
      chk("fx grants", glog_fx.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < glog_rr.size())
            chk($sformatf("rr seq%0d", i), glog_rr[i], exp_rr[i]);
         if (i < glog_fx.size())
            chk($sformatf("fx seq%0d", i), glog_fx[i], exp_fx[i]);
      end
      chk("rr rd0", rd[0][0], 18'h11111);
      chk("rr rd1", rd[0][1], 18'h22222);

      // port 1 drops req during GRANT
      for (int d = 0; d < 2; d++) begin
         req[d][1]  = 1'b1;
         we[d][1]   = 1'b0;
         addr[d][1] = 10'h3FF;
      end
      step();
      drop_all();
      n_ack = 0;
      repeat (6) begin
         step();
         if (ack[0][1]) n_ack++;
         if (ack[1][1]) n_ack++;
      end
      chk("drop acks", n_ack, 2);
      chk("drop rd rr", rd[0][1], 18'h15A5A);
      chk("drop rd fx", rd[1][1], 18'h15A5A);

      // async reset while in RESP; the write is already committed
      for (int d = 0; d < 2; d++) begin
         req[d][0]  = 1'b1;
         we[d][0]   = 1'b1;
         addr[d][0] = 10'h007;
         wd[d][0]   = 18'h3C3C3;
      end
      step();
      step();
      rst = 1'b1;
      drop_all();
      #1;
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         check_all(d);
      end
      step();
      rst = 1'b0;
      step();
      txn(1'b0, 1'b0, 10'h007, 18'h0);
      for (int d = 0; d < 2; d++)
         chk($sformatf("d%0d rd 007", d), rd[d][0], 18'h3C3C3);

      // random traffic
      for (int c = 0; c < 800; c++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (req[d][p]) begin
                  if (ack[d][p]) begin
                     if ($urandom_range(0, 1) == 1)
                        rand_fields(d, p);
                     else
                        req[d][p] = 1'b0;
                  end
               end else if ($urandom_range(0, 9) < 4) begin
                  req[d][p] = 1'b1;
                  rand_fields(d, p);
               end
            end
         end
      end
      drop_all();
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
